// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel window datapath: default pixel width and
// the flat index of each tap in the 3x3 window (row-major, P4 is the centre).
package sobel_pkg;

  localparam int PIX_W_DEF = 8;

  localparam int P0 = 0;
  localparam int P1 = 1;
  localparam int P2 = 2;
  localparam int P3 = 3;
  localparam int P4 = 4;
  localparam int P5 = 5;
  localparam int P6 = 6;
  localparam int P7 = 7;
  localparam int P8 = 8;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One image line of pixels with a registered read port. The caller presents
// the column it expects next, so the read data is ready when that pixel lands.
module sobel_line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
    rd_q <= mem[rd_addr_i];
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a two-column shift
// register produce one registered window per interior pixel of the frame.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_W      = PIX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] in_pix,
  input  logic             in_valid,
  input  logic             in_sof,
  output logic [PIX_W-1:0] p0,
  output logic [PIX_W-1:0] p1,
  output logic [PIX_W-1:0] p2,
  output logic [PIX_W-1:0] p3,
  output logic [PIX_W-1:0] p4,
  output logic [PIX_W-1:0] p5,
  output logic [PIX_W-1:0] p6,
  output logic [PIX_W-1:0] p7,
  output logic [PIX_W-1:0] p8,
  output logic             win_valid,
  output logic             win_eof
);

  localparam int CW = cnt_width(IMG_WIDTH);
  localparam int RW = cnt_width(IMG_HEIGHT);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0]    col_q, col_d, acc_col;
  logic [RW-1:0]    row_q, row_d, acc_row;
  logic             emit, last_pix;
  logic [PIX_W-1:0] line0_rd, line1_rd;
  logic [PIX_W-1:0] col_a_q [3];
  logic [PIX_W-1:0] col_b_q [3];
  logic [PIX_W-1:0] new_col [3];
  logic [PIX_W-1:0] win_d   [9];
  logic [PIX_W-1:0] p_q     [9];
  logic             win_valid_q, win_eof_q;

  // A start-of-frame pixel overrides whatever position the counters hold.
  assign acc_col  = in_sof ? '0 : col_q;
  assign acc_row  = in_sof ? '0 : row_q;
  assign emit     = in_valid && (acc_row >= RW'(2)) && (acc_col >= CW'(2));
  assign last_pix = (acc_row == LAST_ROW) && (acc_col == LAST_COL);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (rst) begin
      col_d = '0;
      row_d = '0;
    end else if (in_valid) begin
      if (acc_col == LAST_COL) begin
        col_d = '0;
        row_d = (acc_row == LAST_ROW) ? '0 : acc_row + RW'(1);
      end else begin
        col_d = acc_col + CW'(1);
        row_d = acc_row;
      end
    end
  end

  // Read address is the next expected column so the registered read lines up.
  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W), .AW(CW)) u_line0 (
    .clk       (clk),
    .wr_en_i   (in_valid && !rst),
    .wr_addr_i (acc_col),
    .wr_data_i (in_pix),
    .rd_addr_i (col_d),
    .rd_data_o (line0_rd)
  );

  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W), .AW(CW)) u_line1 (
    .clk       (clk),
    .wr_en_i   (in_valid && !rst),
    .wr_addr_i (acc_col),
    .wr_data_i (line0_rd),
    .rd_addr_i (col_d),
    .rd_data_o (line1_rd)
  );

  assign new_col[0] = line1_rd;
  assign new_col[1] = line0_rd;
  assign new_col[2] = in_pix;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_win_row
      assign win_d[3*gi + 0] = col_a_q[gi];
      assign win_d[3*gi + 1] = col_b_q[gi];
      assign win_d[3*gi + 2] = new_col[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      win_eof_q   <= 1'b0;
      for (int i = 0; i < 9; i++) p_q[i] <= '0;
      for (int i = 0; i < 3; i++) begin
        col_a_q[i] <= '0;
        col_b_q[i] <= '0;
      end
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= emit;
      win_eof_q   <= emit && last_pix;
      if (in_valid) begin
        for (int i = 0; i < 3; i++) begin
          col_a_q[i] <= col_b_q[i];
          col_b_q[i] <= new_col[i];
        end
      end
      if (emit) begin
        for (int i = 0; i < 9; i++) p_q[i] <= win_d[i];
      end
    end
  end

  assign p0        = p_q[P0];
  assign p1        = p_q[P1];
  assign p2        = p_q[P2];
  assign p3        = p_q[P3];
  assign p4        = p_q[P4];
  assign p5        = p_q[P5];
  assign p6        = p_q[P6];
  assign p7        = p_q[P7];
  assign p8        = p_q[P8];
  assign win_valid = win_valid_q;
  assign win_eof   = win_eof_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen on a 4x4 image: a frame-array model
// predicts every window and the cycle it must appear in.
module tb_sobel_window_gen;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_pix = '0;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic [7:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;
  logic       win_valid, win_eof;

  sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)) dut (
    .clk(clk), .rst(rst), .in_pix(in_pix), .in_valid(in_valid), .in_sof(in_sof),
    .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6), .p7(p7), .p8(p8),
    .win_valid(win_valid), .win_eof(win_eof)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] win;
    logic        eof;
    int          due;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] img [H][W];
  int         mr = 0;
  int         mc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Modes: 0 ramp 16r+c+off, 1 random, 2 flat 0x80, 3 vertical step.
  function automatic logic [7:0] pix_of(input int mode, input int r, input int c, input int off);
    case (mode)
      0:       return 8'((16 * r + c + off) & 255);
      1:       return 8'($urandom_range(255));
      2:       return 8'h80;
      default: return (c < 2) ? 8'h00 : 8'hFF;
    endcase
  endfunction

  task automatic drive(input logic [7:0] pix, input logic sof, input bit valid);
    int   r, c;
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = valid;
    in_pix   = pix;
    in_sof   = sof;
    if (valid) begin
      r = sof ? 0 : mr;
      c = sof ? 0 : mc;
      img[r][c] = pix;
      if (r >= 2 && c >= 2) begin
        e.win = {img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                 img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                 img[r][c-2],   img[r][c-1],   img[r][c]};
        e.eof = (r == H - 1) && (c == W - 1);
        e.due = cyc + 1;
        q.push_back(e);
      end
      if (c == W - 1) begin
        mc = 0;
        mr = (r == H - 1) ? 0 : r + 1;
      end else begin
        mc = c + 1;
        mr = r;
      end
    end
  endtask

  task automatic idle();
    drive(8'($urandom_range(255)), 1'($urandom_range(1)), 1'b0);
  endtask

  // Sends the first n_pix pixels of a frame; gap>=100 means one idle per pixel.
  task automatic frame(input int mode, input int off, input int n_pix, input int gap, input bit sof_first);
    for (int k = 0; k < n_pix; k++) begin
      if (gap >= 100) idle();
      else begin
        for (int g = 0; g < 8 && $urandom_range(99) < gap; g++) idle();
      end
      drive(pix_of(mode, k / W, k % W, off), sof_first && (k == 0), 1'b1);
    end
    idle();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    in_sof = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({p0, p1, p2, p3, p4, p5, p6, p7, p8, win_valid, win_eof} != 74'd0) begin
      miscompares++;
      $display("FAIL reset_state: got %h required 0",
               {p0, p1, p2, p3, p4, p5, p6, p7, p8, win_valid, win_eof});
    end
    q.delete();
    mr = 0;
    mc = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      while (q.size() > 0 && q[0].due < cyc) begin
        e = q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL missed_window: no win_valid at cycle %0d, required win %h", e.due, e.win);
      end
      if (win_valid) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL spurious_window: got win %h at cycle %0d, required none",
                   {p0, p1, p2, p3, p4, p5, p6, p7, p8}, cyc);
        end else begin
          e = q.pop_front();
          if (e.due != cyc || e.eof != win_eof || e.win != {p0, p1, p2, p3, p4, p5, p6, p7, p8}) begin
            miscompares++;
            $display("FAIL window: got win %h eof %0b cycle %0d, required win %h eof %0b cycle %0d",
                     {p0, p1, p2, p3, p4, p5, p6, p7, p8}, win_eof, cyc, e.win, e.eof, e.due);
          end else begin
            $display("window ok: %h eof %0b cycle %0d", e.win, e.eof, cyc);
          end
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    do_reset();
    frame(0, 0, 16, 0, 1'b1);                 // contiguous frame
    frame(0, 0, 16, 100, 1'b1);               // valid every other cycle
    frame(0, 0, 16, 0, 1'b1);                 // back-to-back frames
    frame(0, 8'h40, 16, 0, 1'b0);
    frame(0, 0, 10, 0, 1'b1);                 // stop after (2,1), reset
    do_reset();
    frame(0, 0, 16, 0, 1'b1);
    frame(0, 0, 7, 0, 1'b1);                  // resync at (1,3)
    frame(0, 0, 16, 0, 1'b1);
    frame(2, 0, 16, 0, 1'b1);                 // flat
    frame(3, 0, 16, 30, 1'b1);                // vertical step
    for (int i = 0; i < 12; i++) begin
      frame(1, 0, $urandom_range(1, 16), $urandom_range(60), 1'b1);
      frame(1, 0, 16, $urandom_range(60), 1'b0);
    end
    repeat (4) idle();
    repeat (2) @(negedge clk);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d windows outstanding, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
